// File: rtl/cpu_bus_memory.sv
// CPU byte-bus responder: on-chip RAM at the bottom of the map plus a 16-byte MMIO page
// (prescaled tick counter, scratch, sticky bus error). Optional irq via CPU_BUS_MEMORY_IRQ_EN.
module cpu_bus_memory #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [7:0]  dataIn,
  output logic [7:0]  dataOut
`ifdef CPU_BUS_MEMORY_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [16:0] RAM_LIMIT = 17'(1) << RAM_AW;
  localparam int          RAM_BYTES = 1 << RAM_AW;

  localparam logic [3:0] OFF_TICK_LO  = 4'h0;
  localparam logic [3:0] OFF_TICK_HI  = 4'h1;
  localparam logic [3:0] OFF_CTRL     = 4'h2;
  localparam logic [3:0] OFF_PRESCALE = 4'h3;
  localparam logic [3:0] OFF_SCRATCH  = 4'h4;

  logic [7:0]        mem [0:RAM_BYTES-1];
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       mmio_diff;
  logic [3:0]        mmio_off;
  logic              ram_hit;
  logic              mmio_hit;
  logic              unmapped;

  logic [15:0] tick;
  logic [7:0]  shadow;
  logic [7:0]  pre_rem;
  logic [7:0]  prescale;
  logic [7:0]  scratch;
  logic        en;
  logic        bus_error;
  logic        irq_bit;

  logic       rd_op;
  logic       illegal;
  logic       ctrl_wr;
  logic       prescale_wr;
  logic       scratch_wr;
  logic       tick_lo_rd;
  logic       pre_tc;
  logic       tick_inc;
  logic       tick_clr;
  logic       err_set;
  logic [7:0] rd_data;

  assign ram_idx   = address[RAM_AW-1:0];
  assign mmio_diff = address - MMIO_BASE;
  assign mmio_off  = mmio_diff[3:0];
  assign ram_hit   = ({1'b0, address} < RAM_LIMIT);
  assign mmio_hit  = !ram_hit && (address >= MMIO_BASE) && (mmio_diff[15:4] == 12'h000);
  assign unmapped  = !ram_hit && !mmio_hit;

  assign rd_op       = read && !write;
  assign illegal     = read && write;
  assign ctrl_wr     = write && mmio_hit && (mmio_off == OFF_CTRL);
  assign prescale_wr = write && mmio_hit && (mmio_off == OFF_PRESCALE);
  assign scratch_wr  = write && mmio_hit && (mmio_off == OFF_SCRATCH);
  assign tick_lo_rd  = rd_op && mmio_hit && (mmio_off == OFF_TICK_LO);

  // Prescaler is a down-counter: terminal count at zero, reloaded from PRESCALE.
  assign pre_tc   = (pre_rem == 8'h00);
  assign tick_inc = en && pre_tc;
  assign tick_clr = ctrl_wr && dataIn[1];
  assign err_set  = illegal || ((read || write) && unmapped);

  always_comb begin
    rd_data = 8'hFF;
    if (ram_hit) begin
      rd_data = mem[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_TICK_LO:  rd_data = tick[7:0];
        OFF_TICK_HI:  rd_data = shadow;
        OFF_CTRL:     rd_data = {bus_error, irq_bit, 5'b00000, en};
        OFF_PRESCALE: rd_data = prescale;
        OFF_SCRATCH:  rd_data = scratch;
        default:      rd_data = 8'h00;
      endcase
    end
  end

  // RAM has no reset; a write edge seen while reset is high is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && write && ram_hit) begin
      mem[ram_idx] <= dataIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut   <= 8'h00;
      tick      <= 16'h0000;
      shadow    <= 8'h00;
      pre_rem   <= 8'h00;
      prescale  <= 8'h00;
      scratch   <= 8'h00;
      en        <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (rd_op) begin
        dataOut <= rd_data;
      end
      if (tick_lo_rd) begin
        shadow <= tick[15:8];
      end

      if (prescale_wr) begin
        pre_rem <= dataIn;
      end else if (en) begin
        pre_rem <= pre_tc ? prescale : (pre_rem - 8'h01);
      end

      if (tick_clr) begin
        tick <= 16'h0000;
      end else if (tick_inc) begin
        tick <= tick + 16'h0001;
      end

      if (ctrl_wr) begin
        en <= dataIn[0];
      end
      if (prescale_wr) begin
        prescale <= dataIn;
      end
      if (scratch_wr) begin
        scratch <= dataIn;
      end

      if (err_set) begin
        bus_error <= 1'b1;
      end else if (ctrl_wr && dataIn[7]) begin
        bus_error <= 1'b0;
      end
    end
  end

`ifdef CPU_BUS_MEMORY_IRQ_EN
  logic irq_pending;
  logic tick_wrap;

  // A clear on the wrapping edge suppresses the increment, so no wrap is seen.
  assign tick_wrap = tick_inc && !tick_clr && (tick == 16'hFFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= 1'b0;
    end else if (tick_wrap) begin
      irq_pending <= 1'b1;
    end else if (ctrl_wr && dataIn[6]) begin
      irq_pending <= 1'b0;
    end
  end

  assign irq_bit = irq_pending;
  assign irq     = irq_pending;
`else
  assign irq_bit = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Scoreboard bench for cpu_bus_memory: per-edge reference model pushes expected read data,
// a negedge monitor pops and compares. Honours CPU_BUS_MEMORY_IRQ_EN when defined.
module tb_cpu_bus_memory;

  localparam int          RAM_AW    = 12;
  localparam logic [15:0] MMIO_BASE = 16'hFF00;
`ifdef CPU_BUS_MEMORY_IRQ_EN
  localparam logic [7:0] IRQ_MASK = 8'h40;
`else
  localparam logic [7:0] IRQ_MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  dataIn = 8'h00;
  logic [7:0]  dataOut;
`ifdef CPU_BUS_MEMORY_IRQ_EN
  logic        irq;
`endif

  cpu_bus_memory #(.RAM_AW(RAM_AW), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .address(address),
    .dataIn(dataIn),
    .dataOut(dataOut)
`ifdef CPU_BUS_MEMORY_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level state, counter counting up 0..PRESCALE.
  typedef struct { logic [7:0] data; bit known; } exp_t;
  exp_t exp_q[$];

  bit         m_en = 0;
  logic [7:0] m_pre = 0;
  int         m_pcnt = 0;
  int         m_tick = 0;
  logic [7:0] m_shadow = 0;
  logic [7:0] m_scratch = 0;
  bit         m_err = 0;
  bit         m_irq = 0;
  logic [7:0] m_ram [int];
  logic [7:0] m_dout = 0;
  bit         m_known = 1;

  task automatic model_reset();
    m_en = 0; m_pre = 0; m_pcnt = 0; m_tick = 0; m_shadow = 0;
    m_scratch = 0; m_err = 0; m_irq = 0; m_dout = 0; m_known = 1;
    exp_q.delete();
  endtask

  task automatic model_step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    int ai, off, nxt_tick;
    bit is_ram, is_mmio, fire, wrapped, err_clr, irq_clr;
    exp_t e;
    ai = int'(a);
    is_ram = ai < (1 << RAM_AW);
    is_mmio = !is_ram && ai >= int'(MMIO_BASE) && ai < int'(MMIO_BASE) + 16;
    off = ai - int'(MMIO_BASE);
    fire = m_en && (m_pcnt == int'(m_pre));
    nxt_tick = fire ? (m_tick + 1) % 65536 : m_tick;
    wrapped = fire && (m_tick == 65535);
    err_clr = 0;
    irq_clr = 0;

    if (r && !w) begin
      e.known = 1;
      e.data = 8'hFF;
      if (is_ram) begin
        e.known = m_ram.exists(ai);
        e.data = e.known ? m_ram[ai] : 8'h00;
      end else if (is_mmio) begin
        case (off)
          0: begin e.data = m_tick[7:0]; m_shadow = m_tick[15:8]; end
          1: e.data = m_shadow;
          2: e.data = {m_err, (IRQ_MASK != 0) && m_irq, 5'b0, m_en};
          3: e.data = m_pre;
          4: e.data = m_scratch;
          default: e.data = 8'h00;
        endcase
      end
      exp_q.push_back(e);
      m_dout = e.data;
      m_known = e.known;
    end

    if (m_en) m_pcnt = fire ? 0 : m_pcnt + 1;

    if (w) begin
      if (is_ram) m_ram[ai] = d;
      else if (is_mmio) begin
        if (off == 2) begin
          m_en = d[0];
          if (d[1]) begin nxt_tick = 0; wrapped = 0; end
          err_clr = d[7];
          irq_clr = d[6];
        end else if (off == 3) begin
          m_pre = d;
          m_pcnt = 0;
        end else if (off == 4) m_scratch = d;
      end
    end
    m_tick = nxt_tick;

    if (r && w || ((r || w) && !is_ram && !is_mmio)) m_err = 1;
    else if (err_clr) m_err = 0;
    if (wrapped) m_irq = 1;
    else if (irq_clr) m_irq = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step(read, write, address, dataIn);
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      check("dout_in_reset", dataOut, 16'h0000);
    end else begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.known) check("read_data", dataOut, mon_e.data);
      end
      if (m_known) check("dout_hold", dataOut, m_dout);
`ifdef CPU_BUS_MEMORY_IRQ_EN
      check("irq_port", irq, m_irq);
`endif
    end
  end

  // One bus cycle issued at a negedge; returns at the following negedge.
  task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    read = r; write = w; address = a; dataIn = d;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [15:0] a, input logic [7:0] exp);
    cyc(1'b1, 1'b0, a, 8'h00);
    check(name, dataOut, exp);
  endtask

  int sel;
  logic [15:0] ra;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_dout", dataOut, 16'h0000);
    rd_expect("reset_ctrl", MMIO_BASE + 16'd2, 8'h00);
    rd_expect("reset_tick_lo", MMIO_BASE, 8'h00);
    rd_expect("reset_prescale", MMIO_BASE + 16'd3, 8'h00);
    rd_expect("reset_scratch", MMIO_BASE + 16'd4, 8'h00);

    cyc(1'b0, 1'b1, 16'h0010, 8'hA5);
    rd_expect("ram_read", 16'h0010, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 8'h00);
      check("ram_hold", dataOut, 16'h00A5);
    end
    cyc(1'b0, 1'b1, 16'h0FFF, 8'h77);
    check("write_keeps_dout", dataOut, 16'h00A5);
    rd_expect("ram_top", 16'h0FFF, 8'h77);
    rd_expect("reserved_off", MMIO_BASE + 16'd15, 8'h00);
    rd_expect("ctrl_no_err", MMIO_BASE + 16'd2, 8'h00);

    rd_expect("unmapped_read", 16'h8000, 8'hFF);
    rd_expect("ctrl_err_set", MMIO_BASE + 16'd2, 8'h80);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h80);
    rd_expect("ctrl_err_clr", MMIO_BASE + 16'd2, 8'h00);
    cyc(1'b0, 1'b1, 16'h1000, 8'h11);
    rd_expect("unmapped_ram_edge", 16'h1000, 8'hFF);
    rd_expect("unmapped_below_mmio", 16'hFEFF, 8'hFF);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h80);

    cyc(1'b0, 1'b1, MMIO_BASE + 16'd3, 8'h03);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h01);
    repeat (40) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    rd_expect("tick_lo_40", MMIO_BASE, 8'h0A);
    rd_expect("tick_hi_40", MMIO_BASE + 16'd1, 8'h00);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h00);

    cyc(1'b0, 1'b1, MMIO_BASE + 16'd3, 8'h00);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h03);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    rd_expect("wrap_lo", MMIO_BASE, 8'hFF);
    rd_expect("wrap_hi", MMIO_BASE + 16'd1, 8'hFF);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h00);
    rd_expect("after_wrap_lo", MMIO_BASE, 8'h02);
    rd_expect("irq_pending", MMIO_BASE + 16'd2, IRQ_MASK);
    cyc(1'b0, 1'b1, MMIO_BASE + 16'd2, 8'h40);
    rd_expect("irq_cleared", MMIO_BASE + 16'd2, 8'h00);

    rd_expect("pre_illegal", 16'h0010, 8'hA5);
    cyc(1'b1, 1'b1, MMIO_BASE + 16'd4, 8'h3C);
    check("illegal_hold", dataOut, 16'h00A5);
    rd_expect("illegal_scratch", MMIO_BASE + 16'd4, 8'h3C);
    rd_expect("illegal_err", MMIO_BASE + 16'd2, 8'h80);

    cyc(1'b0, 1'b1, 16'h0020, 8'h5A);
    rd_expect("pre_reset_read", 16'h0020, 8'h5A);
    read = 1'b0; write = 1'b1; address = 16'h0020; dataIn = 8'hC3;
    #2 reset = 1'b1;
    #1 check("async_reset_dout", dataOut, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    rd_expect("reset_aborts_write", 16'h0020, 8'h5A);
    rd_expect("reset_clears_err", MMIO_BASE + 16'd2, 8'h00);

    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: ra = 16'($urandom_range(0, 63));
        2:    ra = 16'($urandom_range(16'h1000, 16'hFEFF));
        3:    ra = 16'($urandom_range(16'hFF10, 16'hFFFF));
        default: ra = MMIO_BASE + 16'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 9))
        0:       cyc(1'b0, 1'b0, ra, 8'h00);
        1:       cyc(1'b1, 1'b1, ra, 8'($urandom));
        2, 3, 4: cyc(1'b0, 1'b1, ra, 8'($urandom_range(0, 255)) & ((ra == MMIO_BASE + 16'd3) ? 8'h07 : 8'hFF));
        default: cyc(1'b1, 1'b0, ra, 8'h00);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_memory.md
Name: cpu_bus_memory

Overview:
- Responder on the CPU byte bus (read/write strobes, 16-bit address, 8-bit data); services every access issued by the Cpu core.
- Provides on-chip RAM at the bottom of the address map, plus a small MMIO page holding a prescaled 16-bit tick counter, a scratch register and a sticky bus-error flag.
- Read data is registered and appears one clock after the strobe, matching the core's one-cycle fetch timing.

Parameters:
- RAM_AW, 12: RAM address width. RAM occupies 0x0000 to 2^RAM_AW-1. Legal range 8 to 15.
- MMIO_BASE, 16'hFF00: base of the 16-byte MMIO page. Must not overlap RAM.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  read strobe from the CPU.
- write  in  1  write strobe from the CPU.
- address  in  16  byte address.
- dataIn  in  8  write data from the CPU.
- dataOut  out  8  registered read data to the CPU.

Behaviour:
- Reset (async, active-high) values:
  - dataOut=0x00, tick counter=0x0000, shadow=0x00, prescale counter=0.
  - CTRL.en=0, PRESCALE=0x00, SCRATCH=0x00, busError=0.
  - RAM contents are not reset.
- Read:
  - On the edge where read=1 and write=0, dataOut loads the addressed byte.
  - The value is valid from that edge and held until the next read edge.
- Write:
  - On the edge where write=1, the byte at address is updated. It is visible to a read issued on the next cycle.
  - dataOut is unchanged by a write.
- read=1 and write=1 together is illegal: perform the write only, hold dataOut, set busError.
- Address decode:
  - RAM region: normal read/write.
  - MMIO page [MMIO_BASE, MMIO_BASE+15]: register access as below.
  - Anything else is unmapped: reads return 0xFF, writes are ignored, and busError is set either way.
- MMIO registers (offset from MMIO_BASE):
  - 0x0 TICK_LO (RO): returns counter[7:0] and, on the same edge, latches counter[15:8] into the shadow register.
  - 0x1 TICK_HI (RO): returns the shadow register, giving an atomic 16-bit read when LO is read first.
  - 0x2 CTRL:
    - write bit0 = en; bit1 = clear counter (self-clearing, reads 0); bit7 = 1 clears busError.
    - read returns {busError, irqPending, 5'b0, en}.
  - 0x3 PRESCALE (RW): any write also zeroes the prescale counter.
  - 0x4 SCRATCH (RW).
  - 0x5 to 0xF: read 0x00, writes ignored. These are not an error.
- Writes to RO offsets are ignored, no error.
- Tick counter:
  - While en=1, the prescale counter counts 0..PRESCALE.
  - On the clock where it equals PRESCALE, it returns to 0 and the tick counter increments.
  - PRESCALE=0 means the tick counter increments every clock.
  - The tick counter wraps 0xFFFF to 0x0000.
  - While en=0, both counters hold.
- Tick counter priority: reset > CTRL clear > increment.
  - A clear written on the same edge as an increment yields 0x0000.
- A TICK_LO read on an incrementing edge returns the pre-increment low byte and latches the pre-increment high byte.
- busError: set by an unmapped or illegal access on the same edge a CTRL clear is written means it stays set (set wins).
- Reset asserted mid-access aborts it: no RAM write occurs while reset is high, and outputs return to reset values immediately.

Optional Feature:
- Macro CPU_BUS_MEMORY_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), driven from the irqPending register.
  - irqPending is set when an increment wraps the tick counter from 0xFFFF to 0x0000.
  - irqPending is cleared by a CTRL write with bit6=1. If set and clear coincide, set wins.
  - Reset value 0.
- Not defined:
  - No irq port.
  - CTRL bit6 reads 0.
  - No wrap-detect logic is built.

Test Plan:
- Reset, then write 0xA5 to 0x0010; next cycle read 0x0010 -> dataOut=0xA5 one edge after the strobe, held through 3 idle cycles.
- Read 0x8000 (unmapped) -> dataOut=0xFF and CTRL reads 0x80. Write CTRL=0x80 -> CTRL reads 0x00.
- PRESCALE=3, CTRL=0x01, run 40 clocks -> counter=10 (±1 for enable edge). Read LO then HI -> consistent 16-bit value 0x000A.
- Counter preset near 0xFFFF via PRESCALE=0 and enable for 65536 clocks -> counter=0x0000. With CPU_BUS_MEMORY_IRQ_EN: irq=1 after the wrap; CTRL write 0x40 -> irq=0.
- read=1 and write=1 to SCRATCH with 0x3C -> SCRATCH=0x3C, dataOut unchanged, busError=1.
- Assert reset during a write strobe to 0x0020 -> the RAM byte is unchanged and dataOut=0x00 immediately, without waiting for a clock edge.
